// File: rtl/comma_code_tx_if.sv
// Bundles the index handshake and the serial/parallel output signals
// of the comma-code transmitter.
// master: the surrounding logic (drives the index, observes the outputs).
// slave:  the transmitter itself.
interface comma_code_tx_if #(
  parameter int word_size  = 16,
  parameter int index_size = 4
);
  logic [index_size-1:0] index_in;
  logic                  index_valid;
  logic                  index_ready;
  logic                  serial_out;
  logic                  serial_valid;
  logic [word_size-1:0]  word_out;
  logic                  word_valid;
  logic                  err_out;
  logic                  busy;

  modport master (
    output index_in, index_valid,
    input  index_ready, serial_out, serial_valid, word_out, word_valid, err_out, busy
  );

  modport slave (
    input  index_in, index_valid,
    output index_ready, serial_out, serial_valid, word_out, word_valid, err_out, busy
  );
endinterface

// File: rtl/comma_code_tx.sv
// Comma-code transmitter: sends index n as n zero bits followed by a single
// comma bit, and presents the one-hot parallel word (bit n set) with the comma.
module comma_code_tx #(
  parameter int word_size  = 16,
  parameter int index_size = 4
) (
  input  logic             trigger,
  input  logic             reset,
  comma_code_tx_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ZERO  = 2'd1;
  localparam logic [1:0] COMMA = 2'd2;

  // word_size always fits in index_size+1 bits because 2**index_size >= word_size
  localparam logic [index_size:0] word_size_w = (index_size + 1)'(word_size);

  logic [1:0]            state_reg, state_next;
  logic [index_size-1:0] cnt_reg, cnt_next;
  logic [index_size-1:0] idx_reg, idx_next;
  logic                  err_next;
  logic [word_size-1:0]  onehot_next;

  logic                  serial_out_reg;
  logic                  serial_valid_reg;
  logic [word_size-1:0]  word_out_reg;
  logic                  word_valid_reg;
  logic                  err_reg;
  logic                  busy_reg;

  logic                  transfer;
  logic                  idx_oob;

  // New index can be taken while idle or while the comma of the previous
  // symbol is on the line, so symbols chain without a gap.
  assign bus.index_ready = (state_reg == IDLE) || (state_reg == COMMA);
  assign transfer        = bus.index_valid && bus.index_ready;
  assign idx_oob         = {1'b0, bus.index_in} >= word_size_w;

  // Next-state, counter and captured-index logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    err_next   = 1'b0;
    case (state_reg)
      ZERO: begin
        // Counter is loaded with n-1, so reaching 0 means the last zero bit
        // is on the line now.
        if (cnt_reg == '0) begin
          state_next = COMMA;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      IDLE, COMMA: begin
        state_next = IDLE;
        if (transfer) begin
          idx_next = bus.index_in;
          if (idx_oob) begin
            err_next = 1'b1;
          end else if (bus.index_in == '0) begin
            state_next = COMMA;
          end else begin
            state_next = ZERO;
            cnt_next   = bus.index_in - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One-hot image of the index entering the comma cycle; bits above
  // word_size simply do not exist, which truncates the shift.
  generate
    for (genvar gi = 0; gi < word_size; gi++) begin : g_onehot
      assign onehot_next[gi] = (idx_next == index_size'(gi));
    end
  endgenerate

  // State, counter and index registers.
  always_ff @(posedge trigger or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe; word_out only changes on a comma cycle.
  always_ff @(posedge trigger or posedge reset) begin
    if (reset) begin
      serial_out_reg   <= 1'b0;
      serial_valid_reg <= 1'b0;
      word_out_reg     <= '0;
      word_valid_reg   <= 1'b0;
      err_reg          <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      serial_out_reg   <= (state_next == COMMA);
      serial_valid_reg <= (state_next != IDLE);
      word_valid_reg   <= (state_next == COMMA);
      err_reg          <= err_next;
      busy_reg         <= (state_next != IDLE);
      if (state_next == COMMA) begin
        word_out_reg <= onehot_next;
      end
    end
  end

  assign bus.serial_out   = serial_out_reg;
  assign bus.serial_valid = serial_valid_reg;
  assign bus.word_out     = word_out_reg;
  assign bus.word_valid   = word_valid_reg;
  assign bus.err_out      = err_reg;
  assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_comma_code_tx.sv
// Bench for comma_code_tx: a scoreboard queue of expected code bits is filled
// as indices are issued and drained by a monitor on the falling edge. A second
// instance with word_size=12 covers the out-of-range index path.
module tb_comma_code_tx;

  logic trigger = 1'b0;
  logic reset;

  always #5 trigger = ~trigger;

  comma_code_tx_if #(.word_size(16), .index_size(4)) bus16 ();
  comma_code_tx_if #(.word_size(12), .index_size(4)) bus12 ();

  comma_code_tx #(.word_size(16), .index_size(4)) dut16 (
    .trigger(trigger), .reset(reset), .bus(bus16.slave)
  );
  comma_code_tx #(.word_size(12), .index_size(4)) dut12 (
    .trigger(trigger), .reset(reset), .bus(bus12.slave)
  );

  typedef struct {
    logic        sout;
    logic        wv;
    logic [15:0] word;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wv_seen  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_symbol(input int n);
    exp_t e;
    logic [15:0] one;
    one = 16'h0001;
    for (int i = 0; i < n; i++) begin
      e.sout = 1'b0; e.wv = 1'b0; e.word = 16'h0; e.idx = n;
      exp_q.push_back(e);
    end
    e.sout = 1'b1; e.wv = 1'b1; e.word = one << n; e.idx = n;
    exp_q.push_back(e);
  endtask

  // Receiver model: position of the single set bit, or -1 if not one-hot.
  function automatic int rx_decode(input logic [15:0] w);
    int pos;
    int cnt;
    pos = -1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (w[i]) begin
        pos = i;
        cnt++;
      end
    end
    return (cnt == 1) ? pos : -1;
  endfunction

  // Issue an index on dut16 and record the code it should produce.
  task automatic send_sym(input int n);
    push_symbol(n);
    bus16.index_in    = 4'(n);
    bus16.index_valid = 1'b1;
    for (int i = 0; i < 40 && !bus16.index_ready; i++) begin
      @(posedge trigger); #1;
    end
    chk("send_ready", 32'(bus16.index_ready), 32'd1);
    @(posedge trigger); #1;
    bus16.index_valid = 1'b0;
    $display("issued index %0d", n);
  endtask

  // Monitor: every serial bit on dut16 must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge trigger);
      if (!reset && bus16.word_valid) begin
        chk("word_valid_without_serial", 32'(bus16.serial_valid), 32'd1);
      end
      if (!reset && bus16.serial_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_serial_bit", 32'(bus16.serial_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("serial_out", 32'(bus16.serial_out), 32'(e.sout));
          chk("word_valid", 32'(bus16.word_valid), 32'(e.wv));
          if (e.wv) begin
            wv_seen++;
            chk("word_out", 32'(bus16.word_out), 32'(e.word));
            chk("loopback_index", rx_decode(bus16.word_out), e.idx);
            $display("comma idx=%0d word_out=0x%04h", e.idx, bus16.word_out);
          end
        end
      end
    end
  end

  // Watchdog: no run should come near this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    bus16.index_in = '0; bus16.index_valid = 1'b0;
    bus12.index_in = '0; bus12.index_valid = 1'b0;
    repeat (2) @(posedge trigger);
    #1;
    chk("rst_serial_valid", 32'(bus16.serial_valid), 32'd0);
    chk("rst_serial_out",   32'(bus16.serial_out),   32'd0);
    chk("rst_word_valid",   32'(bus16.word_valid),   32'd0);
    chk("rst_word_out",     32'(bus16.word_out),     32'd0);
    chk("rst_err",          32'(bus16.err_out),      32'd0);
    chk("rst_busy",         32'(bus16.busy),         32'd0);
    chk("rst_ready",        32'(bus16.index_ready),  32'd1);
    chk("rst_ready12",      32'(bus12.index_ready),  32'd1);
    @(negedge trigger); #2;
    reset = 1'b0;
    @(posedge trigger); #1;

    // Reset mid-symbol: index 10, abort after four zero bits.
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.sout = 1'b0; e.wv = 1'b0; e.word = 16'h0; e.idx = 10;
      exp_q.push_back(e);
    end
    bus16.index_in = 4'd10; bus16.index_valid = 1'b1;
    @(posedge trigger); #1;
    bus16.index_valid = 1'b0;
    chk("abort_busy", 32'(bus16.busy), 32'd1);
    repeat (3) @(posedge trigger);
    @(negedge trigger); #2;
    reset = 1'b1;
    #1;
    chk("abort_serial_valid", 32'(bus16.serial_valid), 32'd0);
    chk("abort_busy_cleared", 32'(bus16.busy),         32'd0);
    chk("abort_ready",        32'(bus16.index_ready),  32'd1);
    @(posedge trigger); @(negedge trigger); #2;
    reset = 1'b0;
    repeat (14) @(posedge trigger);
    #1;
    chk("abort_idle",     32'(bus16.busy),    32'd0);
    chk("abort_no_comma", wv_seen,            0);
    chk("abort_drained",  exp_q.size(),       0);
    $display("reset mid-symbol done");

    // Zero index: comma immediately, then idle.
    send_sym(0);
    @(posedge trigger); #1;
    chk("zero_then_idle", 32'(bus16.serial_valid), 32'd0);
    chk("zero_busy",      32'(bus16.busy),         32'd0);
    chk("zero_word_held", 32'(bus16.word_out),     32'h0001);

    // Mid index: six code bits in total.
    send_sym(5);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus16.serial_valid) cnt++;
      @(posedge trigger); #1;
    end
    chk("mid_bit_count", cnt, 6);
    chk("mid_word_held", 32'(bus16.word_out), 32'h0020);

    // Max index with 3 queued behind it, accepted on the comma cycle.
    push_symbol(15);
    bus16.index_in = 4'd15; bus16.index_valid = 1'b1;
    @(posedge trigger); #1;
    push_symbol(3);
    bus16.index_in = 4'd3;
    cnt = 0;
    for (int i = 0; i < 40 && !bus16.index_ready; i++) begin
      cnt++;
      @(posedge trigger); #1;
    end
    chk("max_ready_low_cycles", cnt, 15);
    @(posedge trigger); #1;
    bus16.index_valid = 1'b0;
    chk("b2b_word_after_15", 32'(bus16.word_out), 32'h8000);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_no_gap", 32'(bus16.serial_valid), 32'd1);
      @(posedge trigger); #1;
    end
    chk("b2b_end_idle", 32'(bus16.serial_valid), 32'd0);
    chk("b2b_word_3",   32'(bus16.word_out),     32'h0008);

    // Loopback for index 7 as well.
    send_sym(7);
    repeat (10) @(posedge trigger);
    #1;

    // Error path on the word_size=12 instance.
    bus12.index_in = 4'd2; bus12.index_valid = 1'b1;
    @(posedge trigger); #1;
    bus12.index_valid = 1'b0;
    repeat (4) @(posedge trigger);
    #1;
    chk("w12_word_2", 32'(bus12.word_out), 32'h004);
    bus12.index_in = 4'd13; bus12.index_valid = 1'b1;
    @(posedge trigger); #1;
    bus12.index_valid = 1'b0;
    chk("err13_pulse",        32'(bus12.err_out),      32'd1);
    chk("err13_no_serial",    32'(bus12.serial_valid), 32'd0);
    chk("err13_busy",         32'(bus12.busy),         32'd0);
    chk("err13_word_kept",    32'(bus12.word_out),     32'h004);
    @(posedge trigger); #1;
    chk("err13_pulse_end",    32'(bus12.err_out),      32'd0);
    chk("err13_still_silent", 32'(bus12.serial_valid), 32'd0);
    $display("error index 13 done");
    bus12.index_in = 4'd12; bus12.index_valid = 1'b1;
    @(posedge trigger); #1;
    bus12.index_valid = 1'b0;
    chk("err12_pulse",     32'(bus12.err_out),      32'd1);
    chk("err12_no_serial", 32'(bus12.serial_valid), 32'd0);
    $display("error index 12 done");

    repeat (3) @(posedge trigger);
    #1;
    chk("final_drained", exp_q.size(), 0);
    chk("final_commas",  wv_seen,      5);
    chk("final_no_err16", 32'(bus16.err_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comma_code_tx.md
Name: comma_code_tx

Overview:
- Transmit side of the comma-code link. Takes an index value and emits it serially as a unary comma code: `n` zero bits followed by a single `1` comma bit.
- On the comma cycle, it also presents the equivalent parallel word. That word has only bit `n` set, so the downstream comma-code receiver returns index `n`.
- Sits between the index producer (valid/ready handshake) and the serial line or receiver.

Parameters:
- `word_size`, 16, width of the parallel word and the maximum symbol length.
- `index_size`, 4, width of the index input; must satisfy `2**index_size >= word_size`.

Ports:
- `trigger`  input  1  clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `index_in`  input  `index_size`  index to transmit.
- `index_valid`  input  1  `index_in` is valid this cycle.
- `index_ready`  output  1  block can accept an index this cycle.
- `serial_out`  output  1  current code bit.
- `serial_valid`  output  1  `serial_out` carries a code bit this cycle.
- `word_out`  output  `word_size`  parallel word of the symbol just completed; one-hot at the index position.
- `word_valid`  output  1  one-cycle pulse, coincident with the comma bit.
- `err_out`  output  1  one-cycle pulse: an accepted index was `>= word_size`.
- `busy`  output  1  a symbol is in progress.

Behaviour:
- Reset (asynchronous, `reset`=1):
  - State goes to IDLE and the counter to 0.
  - `index_ready`=1 (combinational from IDLE).
  - `serial_out`=0, `serial_valid`=0, `word_out`=0, `word_valid`=0, `err_out`=0, `busy`=0.
  - Reset mid-symbol aborts the symbol. No comma is emitted and no `word_valid` is issued.
- Handshake:
  - A transfer occurs on a rising edge where `index_valid`=1 and `index_ready`=1.
  - `index_ready`=1 in IDLE and in COMMA (back-to-back acceptance); 0 in ZERO.
  - `index_in` is captured into an internal register at transfer.
  - The producer holds `index_in` and `index_valid` stable until the transfer occurs.
- FSM states: IDLE, ZERO, COMMA. All outputs are registered except `index_ready`.
- Transitions on transfer (from IDLE or COMMA) with captured value `n`:
  - `n >= word_size`: `err_out`=1 for the next cycle. State goes to IDLE, no serial bits, `word_out` unchanged.
  - `n`=0: next state COMMA.
  - `n`>0: next state ZERO, with the counter loaded to `n`-1.
- ZERO state:
  - Drives `serial_valid`=1, `serial_out`=0.
  - Each cycle: if counter=0, next state is COMMA; otherwise decrement the counter.
  - Exactly `n` ZERO cycles are emitted.
- COMMA state:
  - Drives `serial_valid`=1, `serial_out`=1, `word_valid`=1, `word_out`=(1 << `n`).
  - Next state: the transfer target if a new index is accepted this cycle, otherwise IDLE.
- Latency and timing:
  - First code bit appears the cycle after transfer.
  - A symbol occupies `n`+1 cycles.
  - Back-to-back symbols have no idle gap.
- `word_out` holds its value until the next COMMA cycle or reset. `word_valid` marks the update.
- `busy` = (state != IDLE).
- In IDLE: `serial_valid`=0, `serial_out`=0.
- Width rules:
  - The counter is `index_size` bits and never wraps; the decrement stops at 0.
  - The one-hot shift is truncated to `word_size` bits.
- `index_valid` while `index_ready`=0 (in ZERO) is ignored. The value is not captured and no error is raised.

Test Plan:
- Reset mid-symbol: accept 10, assert `reset` after 4 serial bits → outputs go to 0 immediately (asynchronous). After release, IDLE, `index_ready`=1, and no `word_valid` was issued.
- Zero index: accept 0 → next cycle `serial_valid`=1, `serial_out`=1, `word_valid`=1, `word_out`=16'h0001; the following cycle is idle.
- Mid index: accept 5 → 5 cycles `serial_out`=0, then the comma with `word_out`=16'h0020. Total 6 `serial_valid` cycles.
- Max index and back-to-back:
  - Accept 15, then hold `index_valid` with 3 → `index_ready` is low for 15 cycles.
  - 3 is accepted on the comma cycle (`word_out`=16'h8000).
  - Then 3 zero bits and a comma (`word_out`=16'h0008) follow with no gap.
- Error path: `word_size`=12, accept 13 → `err_out` pulses 1 cycle, `serial_valid` stays 0, `word_out` unchanged.
- Receiver loopback: feed each completed `word_out` for indices 0, 5, 7, 15 into the comma-code receiver → `index_out` equals the sent index.
